// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
//
// Duty-cycle sequencer between the duty switches and the CCR stage. It moves
// the 7-bit compare value toward a switch-selected target in fixed steps. The
// steps happen only at PWM period boundaries, so the motor gets a soft start
// and a soft stop. BRAKE forces an immediate stop.
//
// Parameters:
//   STEP              duty change per ramp step (1..127)
//   PERIODS_PER_STEP  PWM periods between ramp steps (1..255)
//   KICK_PERIODS      full-duty periods of the kickstart (1..255)
//
// Ports:
//   CLK        system clock, shared with the PWM timer
//   RST        synchronous, active-high reset
//   EN         run request; low ramps duty softly down to 0
//   BRAKE      immediate stop; overrides everything except RST
//   TARGET     requested duty (switches), sampled only on period ticks
//   E          period strobe from the timer (high while its count is 0)
//   DUTY       registered compare value for the CCR stage
//   BUSY       registered; high while kicking or ramping
//   AT_TARGET  registered; DUTY equals the latched target
//
// Build option:
//   RAMP_KICKSTART_EN  when defined, adds a KICK state. Leaving IDLE then
//                      holds full duty for KICK_PERIODS periods before the
//                      normal ramp starts.
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl #(
  parameter int STEP             = 1,
  parameter int PERIODS_PER_STEP = 4,
  parameter int KICK_PERIODS     = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       BRAKE,
  input  logic [6:0] TARGET,
  input  logic       E,
  output logic [6:0] DUTY,
  output logic       BUSY,
  output logic       AT_TARGET
);

  // One period counter serves both the ramp pacing and the kick length.
  // It is therefore sized for the longer of the two.
  localparam int MAX_PERIODS = (PERIODS_PER_STEP > KICK_PERIODS) ?
                               PERIODS_PER_STEP : KICK_PERIODS;
  localparam int CNT_W       = (MAX_PERIODS > 1) ? $clog2(MAX_PERIODS) : 1;

  localparam logic [7:0]       STEP_W    = 8'(STEP);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(PERIODS_PER_STEP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef RAMP_KICKSTART_EN
  localparam logic [CNT_W-1:0] KICK_LAST = CNT_W'(KICK_PERIODS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_RAMP_DOWN = 3'd2,
`ifdef RAMP_KICKSTART_EN
    S_HOLD      = 3'd3,
    S_KICK      = 3'd4
`else
    S_HOLD      = 3'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       duty_q, duty_d;
  logic [6:0]       tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             at_target_q, at_target_d;
  logic             e_q;

  logic       tick;
  logic [6:0] eff_tgt;
  logic [7:0] up_sum;
  logic [6:0] up_val;
  logic [7:0] dn_diff;
  logic [6:0] dn_val;
  logic [6:0] first_val;

  // Rising edge of the period strobe gives exactly one tick per PWM period.
  assign tick    = E & ~e_q;
  assign eff_tgt = EN ? TARGET : 7'd0;

  // The up step is computed 8 bits wide so a step past 127 saturates at the
  // target instead of wrapping.
  assign up_sum    = {1'b0, duty_q} + STEP_W;
  assign up_val    = (up_sum >= {1'b0, eff_tgt}) ? eff_tgt : up_sum[6:0];
  // The down step is only used while duty_q > eff_tgt, so dn_diff is positive.
  assign dn_diff   = {1'b0, duty_q} - {1'b0, eff_tgt};
  assign dn_val    = (dn_diff <= STEP_W) ? eff_tgt : (duty_q - STEP_W[6:0]);
  // This is the first step out of IDLE or KICK, i.e. min(STEP, target).
  assign first_val = (STEP_W >= {1'b0, eff_tgt}) ? eff_tgt : STEP_W[6:0];

  always_comb begin
    // NOTE: every signal assigned in this block gets a hold default first.
    // A branch that forgets it then keeps the old value instead of
    // inferring a latch.
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;

    if (BRAKE) begin
      state_d = S_IDLE;
      duty_d  = 7'd0;
      tgt_d   = 7'd0;
      cnt_d   = '0;
    end else if (tick) begin
      tgt_d = eff_tgt;
      unique case (state_q)
        S_IDLE: begin
          if (eff_tgt != 7'd0) begin
            cnt_d = '0;
`ifdef RAMP_KICKSTART_EN
            state_d = S_KICK;
            duty_d  = 7'h7f;
`else
            // The entry tick already applies the first step.
            duty_d  = first_val;
            state_d = (first_val == eff_tgt) ? S_HOLD : S_RAMP_UP;
`endif
          end
        end

        S_RAMP_UP: begin
          if (eff_tgt < duty_q) begin
            // The target crossed below the duty: reverse, no step this tick.
            state_d = S_RAMP_DOWN;
            cnt_d   = '0;
          end else if (eff_tgt == duty_q) begin
            state_d = (eff_tgt == 7'd0) ? S_IDLE : S_HOLD;
            cnt_d   = '0;
          end else if (cnt_q == STEP_LAST) begin
            duty_d = up_val;
            cnt_d  = '0;
            if (up_val == eff_tgt) state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        S_RAMP_DOWN: begin
          if (eff_tgt > duty_q) begin
            state_d = S_RAMP_UP;
            cnt_d   = '0;
          end else if (eff_tgt == duty_q) begin
            state_d = (eff_tgt == 7'd0) ? S_IDLE : S_HOLD;
            cnt_d   = '0;
          end else if (cnt_q == STEP_LAST) begin
            duty_d = dn_val;
            cnt_d  = '0;
            if (dn_val == eff_tgt) state_d = (eff_tgt == 7'd0) ? S_IDLE : S_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        S_HOLD: begin
          if (eff_tgt > duty_q) begin
            state_d = S_RAMP_UP;
            cnt_d   = '0;
          end else if (eff_tgt < duty_q) begin
            state_d = S_RAMP_DOWN;
            cnt_d   = '0;
          end
        end

`ifdef RAMP_KICKSTART_EN
        S_KICK: begin
          if (eff_tgt == 7'd0) begin
            // A stop request during the kick ramps down from full duty.
            state_d = S_RAMP_DOWN;
            cnt_d   = '0;
          end else if (cnt_q == KICK_LAST) begin
            duty_d  = first_val;
            cnt_d   = '0;
            state_d = (first_val == eff_tgt) ? S_HOLD : S_RAMP_UP;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`endif

        default: begin
          state_d = S_IDLE;
          duty_d  = 7'd0;
          cnt_d   = '0;
        end
      endcase
    end

    // BUSY and AT_TARGET are registered from the next-state values, so they
    // change in the same cycle as DUTY.
    busy_d = (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
`ifdef RAMP_KICKSTART_EN
    busy_d = busy_d || (state_d == S_KICK);
`endif
    at_target_d = (duty_d == tgt_d);
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments only. Every flop
    // then samples its pre-edge inputs, whatever order the simulator runs
    // the blocks in.
    if (RST) begin
      state_q     <= S_IDLE;
      duty_q      <= 7'd0;
      tgt_q       <= 7'd0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      at_target_q <= 1'b1;
      // Clearing e_q means an E held high through reset release ticks.
      e_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      at_target_q <= at_target_d;
      e_q         <= E;
    end
  end

  assign DUTY      = duty_q;
  assign BUSY      = busy_q;
  assign AT_TARGET = at_target_q;

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Duty-cycle sequencer for the motor PWM system. Feeds the 7-bit compare value into the CCR stage instead of the raw switches, and ramps duty toward a switch-selected target in fixed steps at PWM period boundaries. Provides soft start, soft stop on enable drop, and an immediate brake.

## Interface

Parameters:
- STEP, 1, duty increment/decrement per ramp step (1..127)
- PERIODS_PER_STEP, 4, PWM periods between ramp steps (1..255)
- KICK_PERIODS, 2, PWM periods at full duty during kickstart (1..255; used only with the macro)

Ports:
- CLK  in  1  system clock, same clock as the PWM timer
- RST  in  1  synchronous, active-high reset
- EN  in  1  run request; low means soft ramp to 0
- BRAKE  in  1  immediate stop; overrides everything except RST
- TARGET  in  7  requested duty (switches)
- E  in  1  period strobe from the timer block (high while timer count == 0)
- DUTY  out  7  compare value to the CCR stage
- BUSY  out  1  high in KICK, RAMP_UP and RAMP_DOWN
- AT_TARGET  out  1  DUTY equals the latched target

## Operation

- All outputs are registered.
- Reset values:
  - DUTY = 0, BUSY = 0, AT_TARGET = 1.
  - Latched target = 0, step counter = 0, state = IDLE.
- Tick:
  - tick = E & ~E_q, where E_q is E registered.
  - Exactly one tick per PWM period.
  - Nothing except BRAKE and RST acts outside tick cycles.
- Effective target on each tick:
  - Latched as TARGET when EN = 1, or as 0 when EN = 0.
  - Changes between ticks are ignored.
- Step counter:
  - Increments on each tick while in RAMP_UP or RAMP_DOWN.
  - When it reaches PERIODS_PER_STEP-1, a step is applied and the counter clears.
  - The counter clears on every state change.
- States and transitions:
  - IDLE (DUTY = 0): on tick with effective target > 0, go to KICK (macro) or RAMP_UP. Entry into RAMP_UP applies the first step immediately.
  - RAMP_UP:
    - Step: DUTY = min(DUTY+STEP, tgt), computed 8 bits wide; no wrap past 127.
    - When DUTY reaches tgt, go to HOLD.
  - RAMP_DOWN:
    - Step: DUTY = tgt if DUTY-tgt <= STEP, else DUTY-STEP.
    - When DUTY reaches tgt, go to HOLD, or to IDLE if tgt = 0.
  - HOLD: on tick, if tgt > DUTY go to RAMP_UP; if tgt < DUTY go to RAMP_DOWN; otherwise stay.
  - Direction is re-evaluated every tick in RAMP_UP and RAMP_DOWN. A target crossing the current DUTY reverses the state on that tick, with the counter cleared and no step applied that tick.
- BRAKE = 1 in any cycle: next cycle DUTY = 0, state = IDLE, counter = 0, latched target = 0. Held BRAKE keeps the block in IDLE.
- AT_TARGET = (DUTY == latched target), updated with DUTY.

## Timing

- DUTY changes only in the cycle after a tick, i.e. 1 CLK after E rises, or 1 CLK after BRAKE is sampled.
- The downstream CCR samples on its next E rise, so a DUTY change reaches the PWM output one period later.
- Ramp time from 0 to T, without kickstart: ceil(T/STEP) steps. The first step lands on the entry tick; each later step follows PERIODS_PER_STEP ticks after the previous one.
- RST mid-ramp: all state returns to reset values on the next CLK. The E_q register also clears, so an E held high at reset release produces a tick.
- Simultaneous BRAKE and tick: BRAKE wins.
- Simultaneous EN fall and tick: target 0 is latched on that tick.

## Configuration

- RAMP_KICKSTART_EN defined:
  - Adds the KICK state.
  - IDLE→KICK on tick with tgt > 0; DUTY = 127 for KICK_PERIODS ticks.
  - Then DUTY = min(STEP, tgt), going to HOLD if equal, else RAMP_UP.
  - The effective target going to 0 during KICK goes directly to RAMP_DOWN.
  - BUSY is high in KICK.
- RAMP_KICKSTART_EN undefined: no KICK state exists; IDLE goes directly to RAMP_UP.

## Test plan

- Reset, EN = 1, TARGET = 4, STEP = 1, PERIODS_PER_STEP = 4 → DUTY goes 1, 2, 3, 4 at entry tick +0, +4, +8, +12. AT_TARGET rises with DUTY = 4; BUSY falls on the same cycle.
- At DUTY = 10, TARGET changes 10→3 mid-period with STEP = 4 → no change until the next tick. Then RAMP_DOWN: 6 after PERIODS_PER_STEP ticks, then 3, then HOLD.
- At DUTY = 17, EN drops → DUTY ramps down to 0 and the state returns to IDLE. The TARGET value is ignored throughout.
- BRAKE pulsed for 1 CLK in the same cycle as a tick, at DUTY = 60 → DUTY = 0 on the next CLK and the state is IDLE. Ramp restarts from 1 on the next tick.
- TARGET = 127, STEP = 5 → DUTY reaches 125, then saturates to 127 (not 2) and enters HOLD.
- With RAMP_KICKSTART_EN, KICK_PERIODS = 2, TARGET = 20, STEP = 1 → DUTY = 127 for 2 ticks, then 1, then ramps to 20. Without the macro → DUTY = 1 on the first tick.
